neuron_seq: RTL and testbench



---
 rtl/neuron_seq.sv | 191 +++++++++++++++++++
 tb/tb_neuron_seq.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_seq.sv
// neuron_seq: sequencer for one fully-connected layer feeding an external MAC.
// For each neuron it clears the MAC, streams NUM_IN input/weight byte pairs
// from two synchronous ROMs, drains the ROM pipeline, then captures the
// accumulator and emits a shifted, saturated 8-bit result.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               begin layer (sampled only when idle)
//   in_addr, wt_addr    input / weight ROM addresses
//   in_data, wt_data    ROM read data, ROM_LAT cycles after address
//   mac_a, mac_b        MAC operands (zero when no valid data)
//   mac_clr_n           MAC clear, active low
//   mac_acc             MAC accumulator
//   res, res_idx        result byte and neuron index
//   res_vld, done       result strobe, end-of-layer pulse
//   busy                high whenever not idle
// Build option: RELU_EN selects ReLU with 0..255 clamp instead of the
// default signed -128..127 clamp.
module neuron_seq #(
   parameter int NUM_IN  = 784,
   parameter int NUM_NEU = 32,
   parameter int ROM_LAT = 1,
   parameter int SHIFT   = 10,
   localparam int KW = $clog2(NUM_IN),
   localparam int WW = $clog2(NUM_IN * NUM_NEU),
   localparam int NW = (NUM_NEU > 1) ? $clog2(NUM_NEU) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   output logic [KW-1:0] in_addr,
   output logic [WW-1:0] wt_addr,
   input  logic [7:0]    in_data,
   input  logic [7:0]    wt_data,
   output logic [7:0]    mac_a,
   output logic [7:0]    mac_b,
   output logic          mac_clr_n,
   input  logic [25:0]   mac_acc,
   output logic [7:0]    res,
   output logic [NW-1:0] res_idx,
   output logic          res_vld,
   output logic          busy,
   output logic          done
);

   typedef enum logic [2:0] {
      IDLE,
      CLR,
      RUN,
      DRAIN,
      CAPT
   } state_t;

   state_t state;
   state_t nxt;

   logic [KW-1:0]      k;
   logic [WW-1:0]      wa;
   logic [NW-1:0]      n;
   logic [1:0]         dc;
   logic [ROM_LAT-1:0] vp;

   logic k_last;
   logic n_last;
   logic d_last;

   logic signed [25:0] t;
   logic [7:0]         sat;

   assign k_last = (k == KW'(NUM_IN - 1));
   assign n_last = (n == NW'(NUM_NEU - 1));
   assign d_last = (dc == 2'(ROM_LAT - 1));

   assign in_addr = k;
   assign wt_addr = wa;

   // Oldest stage of the valid pipe marks ROM data belonging to an issued address
   assign mac_a = vp[ROM_LAT-1] ? in_data : 8'h00;
   assign mac_b = vp[ROM_LAT-1] ? wt_data : 8'h00;

   assign t = $signed(mac_acc) >>> SHIFT;

   always_comb begin
      sat = 8'h00;
`ifdef RELU_EN
      if (t < 26'sd0)
         sat = 8'h00;
      else if (t > 26'sd255)
         sat = 8'hFF;
      else
         sat = t[7:0];
`else
      if (t < -26'sd128)
         sat = 8'h80;
      else if (t > 26'sd127)
         sat = 8'h7F;
      else
         sat = t[7:0];
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= nxt;
   end

   always_comb begin
      nxt       = state;
      mac_clr_n = 1'b1;
      busy      = 1'b1;
      case (state)
         IDLE: begin
            mac_clr_n = 1'b0;
            busy      = 1'b0;
            if (start)
               nxt = CLR;
         end
         CLR: begin
            mac_clr_n = 1'b0;
            nxt       = RUN;
         end
         RUN: begin
            if (k_last)
               nxt = DRAIN;
         end
         DRAIN: begin
            if (d_last)
               nxt = CAPT;
         end
         CAPT: begin
            nxt = n_last ? IDLE : CLR;
         end
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k       <= '0;
         wa      <= '0;
         n       <= '0;
         dc      <= '0;
         vp      <= '0;
         res     <= '0;
         res_idx <= '0;
         res_vld <= 1'b0;
         done    <= 1'b0;
      end else begin
         vp      <= ROM_LAT'({vp, (state == RUN)});
         res_vld <= (state == CAPT);
         done    <= (state == CAPT) && n_last;
         case (state)
            IDLE: begin
               if (start) begin
                  n  <= '0;
                  wa <= '0;
               end
            end
            CLR: begin
               k  <= '0;
               dc <= '0;
            end
            RUN: begin
               // Hold on the last address so wt_addr never runs past the table
               if (!k_last) begin
                  k  <= k + 1'b1;
                  wa <= wa + 1'b1;
               end
            end
            DRAIN: begin
               dc <= dc + 1'b1;
            end
            CAPT: begin
               res     <= sat;
               res_idx <= n;
               if (n_last) begin
                  n  <= '0;
                  k  <= '0;
                  wa <= '0;
               end else begin
                  n  <= n + 1'b1;
                  wa <= wa + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_neuron_seq.sv
// tb_neuron_seq: directed bench for neuron_seq with NUM_IN=4, NUM_NEU=2,
// ROM_LAT=1; a second instance uses SHIFT=2 with constant ROM data.
module tb_neuron_seq;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [1:0] in_addr;
   logic [2:0] wt_addr;
   logic [7:0] in_data;
   logic [7:0] wt_data;
   logic [7:0] mac_a;
   logic [7:0] mac_b;
   logic       mac_clr_n;
   logic [25:0] mac_acc;
   logic [7:0] res;
   logic [0:0] res_idx;
   logic       res_vld;
   logic       busy;
   logic       done;

   logic [1:0] in_addr2;
   logic [2:0] wt_addr2;
   logic [7:0] mac_a2;
   logic [7:0] mac_b2;
   logic       mac_clr_n2;
   logic [25:0] mac_acc2;
   logic [7:0] res2;
   logic [0:0] res_idx2;
   logic       res_vld2;
   logic       busy2;
   logic       done2;

   logic [7:0] in_mem [4];
   logic [7:0] wt_mem [8];

   int n_chk;
   int n_fail;

   int         nvld;
   int         ndone;
   int         vcyc [4];
   logic [7:0] vres [4];
   int         vidx [4];
   int         vdone [4];
   logic [2:0] wseq [8];
   int         nv2;
   logic [7:0] r2 [2];

`ifdef RELU_EN
   localparam logic [7:0] E_BIG = 8'hFF;
   localparam logic [7:0] E_NEG = 8'h00;
`else
   localparam logic [7:0] E_BIG = 8'h7F;
   localparam logic [7:0] E_NEG = 8'hFC;
`endif

   neuron_seq #(
      .NUM_IN (4),
      .NUM_NEU(2),
      .ROM_LAT(1),
      .SHIFT  (0)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .in_addr  (in_addr),
      .wt_addr  (wt_addr),
      .in_data  (in_data),
      .wt_data  (wt_data),
      .mac_a    (mac_a),
      .mac_b    (mac_b),
      .mac_clr_n(mac_clr_n),
      .mac_acc  (mac_acc),
      .res      (res),
      .res_idx  (res_idx),
      .res_vld  (res_vld),
      .busy     (busy),
      .done     (done)
   );

   neuron_seq #(
      .NUM_IN (4),
      .NUM_NEU(2),
      .ROM_LAT(1),
      .SHIFT  (2)
   ) dut2 (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .in_addr  (in_addr2),
      .wt_addr  (wt_addr2),
      .in_data  (8'd5),
      .wt_data  (8'd3),
      .mac_a    (mac_a2),
      .mac_b    (mac_b2),
      .mac_clr_n(mac_clr_n2),
      .mac_acc  (mac_acc2),
      .res      (res2),
      .res_idx  (res_idx2),
      .res_vld  (res_vld2),
      .busy     (busy2),
      .done     (done2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      in_data <= in_mem[in_addr];
      wt_data <= wt_mem[wt_addr];
   end

   logic signed [7:0]  sa;
   logic signed [7:0]  sb;
   logic signed [15:0] prod;
   logic signed [7:0]  sa2;
   logic signed [7:0]  sb2;
   logic signed [15:0] prod2;
   assign sa    = mac_a;
   assign sb    = mac_b;
   assign prod  = sa * sb;
   assign sa2   = mac_a2;
   assign sb2   = mac_b2;
   assign prod2 = sa2 * sb2;

   always @(posedge clk) begin
      if (!mac_clr_n)
         mac_acc <= '0;
      else
         mac_acc <= mac_acc + 26'(prod);
      if (!mac_clr_n2)
         mac_acc2 <= '0;
      else
         mac_acc2 <= mac_acc2 + 26'(prod2);
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic fill(input logic [7:0] iv, input logic [7:0] w0,
                       input logic [7:0] w1);
      for (int i = 0; i < 4; i++) begin
         in_mem[i]   = iv;
         wt_mem[i]   = w0;
         wt_mem[i+4] = w1;
      end
   endtask

   task automatic run_layer(input bit restart);
      nvld  = 0;
      ndone = 0;
      nv2   = 0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int m = 1; m <= 20; m++) begin
         start = (restart && m == 3);
         if (m >= 2 && m <= 5)
            wseq[m-2] = wt_addr;
         if (m >= 9 && m <= 12)
            wseq[m-5] = wt_addr;
         if (res_vld) begin
            if (nvld < 4) begin
               vcyc[nvld]  = m;
               vres[nvld]  = res;
               vidx[nvld]  = int'(res_idx);
               vdone[nvld] = int'(done);
            end
            nvld++;
         end
         if (done)
            ndone++;
         if (res_vld2 && nv2 < 2) begin
            r2[nv2] = res2;
            nv2++;
         end
         @(negedge clk);
      end
      start = 1'b0;
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      rst_n  = 1'b0;
      start  = 1'b0;
      fill(8'd0, 8'd0, 8'd0);
      repeat (3) @(negedge clk);
      chk("rst_res", res, 0);
      chk("rst_idx", res_idx, 0);
      chk("rst_vld", res_vld, 0);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_clr", mac_clr_n, 0);
      chk("rst_inaddr", in_addr, 0);
      chk("rst_wtaddr", wt_addr, 0);
      rst_n = 1'b1;

      // all ones
      fill(8'd1, 8'd1, 8'd1);
      run_layer(1'b0);
      chk("t1_nvld", nvld, 2);
      chk("t1_cyc0", vcyc[0], 8);
      chk("t1_cyc1", vcyc[1], 15);
      chk("t1_res0", vres[0], 4);
      chk("t1_res1", vres[1], 4);
      chk("t1_idx0", vidx[0], 0);
      chk("t1_idx1", vidx[1], 1);
      chk("t1_done0", vdone[0], 0);
      chk("t1_done1", vdone[1], 1);
      chk("t1_ndone", ndone, 1);
      chk("t1_busy", busy, 0);
      chk("sh2_nvld", nv2, 2);
      chk("sh2_res0", r2[0], 15);
      chk("sh2_res1", r2[1], 15);

      // large positive saturates
      fill(8'd127, 8'd127, 8'd127);
      run_layer(1'b0);
      chk("t2_nvld", nvld, 2);
      chk("t2_res0", vres[0], E_BIG);
      chk("t2_res1", vres[1], E_BIG);

      // negative and positive neurons, start pulsed during RUN
      fill(8'd1, 8'hFF, 8'd2);
      run_layer(1'b1);
      chk("t3_nvld", nvld, 2);
      chk("t3_ndone", ndone, 1);
      chk("t3_res0", vres[0], E_NEG);
      chk("t3_res1", vres[1], 8);
      chk("t3_idx1", vidx[1], 1);
      for (int i = 0; i < 8; i++)
         chk($sformatf("t3_wseq%0d", i), wseq[i], i);
      chk("t3_hold", res, 8);
      chk("t3_busy", busy, 0);

      // reset during neuron 1 RUN
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      chk("t4_busy_pre", busy, 1);
      chk("t4_res_pre", res, E_NEG);
      rst_n = 1'b0;
      #1;
      chk("t4_res", res, 0);
      chk("t4_idx", res_idx, 0);
      chk("t4_vld", res_vld, 0);
      chk("t4_done", done, 0);
      chk("t4_busy", busy, 0);
      chk("t4_clr", mac_clr_n, 0);
      chk("t4_wtaddr", wt_addr, 0);
      @(negedge clk);
      rst_n = 1'b1;
      nvld  = 0;
      ndone = 0;
      for (int m = 0; m < 12; m++) begin
         if (res_vld)
            nvld++;
         if (done)
            ndone++;
         @(negedge clk);
      end
      chk("t4_novld", nvld, 0);
      chk("t4_nodone", ndone, 0);

      // fresh layer after reset
      run_layer(1'b0);
      chk("t5_nvld", nvld, 2);
      chk("t5_cyc0", vcyc[0], 8);
      chk("t5_res0", vres[0], E_NEG);
      chk("t5_res1", vres[1], 8);
      chk("t5_done1", vdone[1], 1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
